// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Free-running
//               column/line counters advanced by a pixel-clock enable, with
//               registered sync, blanking and line/frame start strobes that
//               are decoded from the next counter value so they stay coherent
//               with HControl/VControl in the same cycle.
//               Optional macro VGA_TIMING_PREFETCH_EN adds fetchX/fetchY/
//               fetchValid, which show the coordinate of the next pixel tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             normalCLK,
  input  logic             resetN,
  input  logic             pixEn,
`ifdef VGA_TIMING_PREFETCH_EN
  output logic [CNT_W-1:0] fetchX,
  output logic [CNT_W-1:0] fetchY,
  output logic             fetchValid,
`endif
  output logic [CNT_W-1:0] HControl,
  output logic [CNT_W-1:0] VControl,
  output logic             hSync,
  output logic             vSync,
  output logic             videoOn,
  output logic             lineStart,
  output logic             frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last counter values before wrapping.
  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);

  // Region bounds held one bit wider so that a sync pulse ending exactly at
  // 2^CNT_W (zero back porch, full-range counter) does not alias to zero.
  localparam logic [CNT_W:0] C_H_ACT    = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] C_HS_BEGIN = (CNT_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W:0] C_HS_END   = (CNT_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] C_V_ACT    = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] C_VS_BEGIN = (CNT_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W:0] C_VS_END   = (CNT_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_q, v_q;
  logic [CNT_W-1:0] h_d, v_d;
  logic             hsync_q, vsync_q, video_q, line_q, frame_q;
  logic             hsync_d, vsync_d, video_d, line_d, frame_d;
  logic [CNT_W:0]   h_d_ext, v_d_ext;

  // Next raster position and the outputs that belong to it.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == C_H_LAST) begin
      h_d = '0;
      if (v_q == C_V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + 1'b1;
      end
    end
    h_d_ext = {1'b0, h_d};
    v_d_ext = {1'b0, v_d};
    hsync_d = ((h_d_ext >= C_HS_BEGIN) && (h_d_ext < C_HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_d_ext >= C_VS_BEGIN) && (v_d_ext < C_VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_d = (h_d_ext < C_H_ACT) && (v_d_ext < C_V_ACT);
    line_d  = (h_d == '0);
    frame_d = (h_d == '0) && (v_d == '0);
  end

  // Counters and decoded outputs advance together on a pixel tick; strobes
  // are cleared on every non-tick cycle so they last one clock only.
  always_ff @(posedge normalCLK or negedge resetN) begin
    if (!resetN) begin
      h_q     <= C_H_LAST;
      v_q     <= C_V_LAST;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (pixEn) begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign HControl   = h_q;
  assign VControl   = v_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign videoOn    = video_q;
  assign lineStart  = line_q;
  assign frameStart = frame_q;

`ifdef VGA_TIMING_PREFETCH_EN
  // The next-tick position is already computed for the registers; exposing
  // it gives a one-cycle memory lookup time to line up with videoOn.
  assign fetchX     = h_d;
  assign fetchY     = v_d;
  assign fetchValid = video_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Three instances
//               (default 800x525, a medium active-low raster and a tiny
//               active-high raster) run against a reference model; expected
//               states are queued before each edge and compared after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit vid;
    bit ls;
    bit fs;
  } st_t;

  typedef struct {
    int ha; int hf; int hw; int hb;
    int va; int vf; int vw; int vb;
    bit pol;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pe_d, pe_m, pe_s;

  logic [9:0] d_h, d_v;
  logic       d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [9:0] m_h, m_v;
  logic       m_hs, m_vs, m_vid, m_ls, m_fs;
  logic [2:0] s_h, s_v;
  logic       s_hs, s_vs, s_vid, s_ls, s_fs;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [9:0] d_fx, d_fy, m_fx, m_fy;
  logic [2:0] s_fx, s_fy;
  logic       d_fv, m_fv, s_fv;
`endif

  vga_timing_gen u_def (
    .normalCLK(clk), .resetN(rst_n), .pixEn(pe_d),
`ifdef VGA_TIMING_PREFETCH_EN
    .fetchX(d_fx), .fetchY(d_fy), .fetchValid(d_fv),
`endif
    .HControl(d_h), .VControl(d_v), .hSync(d_hs), .vSync(d_vs),
    .videoOn(d_vid), .lineStart(d_ls), .frameStart(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) u_med (
    .normalCLK(clk), .resetN(rst_n), .pixEn(pe_m),
`ifdef VGA_TIMING_PREFETCH_EN
    .fetchX(m_fx), .fetchY(m_fy), .fetchValid(m_fv),
`endif
    .HControl(m_h), .VControl(m_v), .hSync(m_hs), .vSync(m_vs),
    .videoOn(m_vid), .lineStart(m_ls), .frameStart(m_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .CNT_W(3)
  ) u_sml (
    .normalCLK(clk), .resetN(rst_n), .pixEn(pe_s),
`ifdef VGA_TIMING_PREFETCH_EN
    .fetchX(s_fx), .fetchY(s_fy), .fetchValid(s_fv),
`endif
    .HControl(s_h), .VControl(s_v), .hSync(s_hs), .vSync(s_vs),
    .videoOn(s_vid), .lineStart(s_ls), .frameStart(s_fs)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  cfg_t cd, cm, cs;
  st_t  md, mm, ms;
  st_t  q_d[$], q_m[$], q_s[$];
  int   last_fs_s = -1, last_fs_m = -1, per_s = 0, per_m = 0;

  function automatic st_t rst_state(cfg_t c);
    st_t s;
    s.h = c.ha + c.hf + c.hw + c.hb - 1;
    s.v = c.va + c.vf + c.vw + c.vb - 1;
    s.hs = ~c.pol; s.vs = ~c.pol;
    s.vid = 1'b0; s.ls = 1'b0; s.fs = 1'b0;
    return s;
  endfunction

  function automatic st_t mstep(st_t s, bit pix, cfg_t c);
    st_t n;
    int ht, vt, hb0, vb0;
    n = s;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (!pix) return n;
    ht = c.ha + c.hf + c.hw + c.hb;
    vt = c.va + c.vf + c.vw + c.vb;
    if (s.h == ht - 1) begin
      n.h = 0;
      n.v = (s.v == vt - 1) ? 0 : s.v + 1;
    end else begin
      n.h = s.h + 1;
    end
    hb0 = c.ha + c.hf;
    vb0 = c.va + c.vf;
    n.hs = (n.h >= hb0 && n.h < hb0 + c.hw) ? c.pol : ~c.pol;
    n.vs = (n.v >= vb0 && n.v < vb0 + c.vw) ? c.pol : ~c.pol;
    n.vid = (n.h < c.ha) && (n.v < c.va);
    n.ls = (n.h == 0);
    n.fs = (n.h == 0) && (n.v == 0);
    return n;
  endfunction

  function automatic st_t obs_d();
    st_t s;
    s.h = int'(d_h); s.v = int'(d_v); s.hs = d_hs; s.vs = d_vs;
    s.vid = d_vid; s.ls = d_ls; s.fs = d_fs;
    return s;
  endfunction

  function automatic st_t obs_m();
    st_t s;
    s.h = int'(m_h); s.v = int'(m_v); s.hs = m_hs; s.vs = m_vs;
    s.vid = m_vid; s.ls = m_ls; s.fs = m_fs;
    return s;
  endfunction

  function automatic st_t obs_s();
    st_t s;
    s.h = int'(s_h); s.v = int'(s_v); s.hs = s_hs; s.vs = s_vs;
    s.vid = s_vid; s.ls = s_ls; s.fs = s_fs;
    return s;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_st(input string nm, input st_t g, input st_t e);
    chk({nm, ".HControl"},   g.h,         e.h);
    chk({nm, ".VControl"},   g.v,         e.v);
    chk({nm, ".hSync"},      int'(g.hs),  int'(e.hs));
    chk({nm, ".vSync"},      int'(g.vs),  int'(e.vs));
    chk({nm, ".videoOn"},    int'(g.vid), int'(e.vid));
    chk({nm, ".lineStart"},  int'(g.ls),  int'(e.ls));
    chk({nm, ".frameStart"}, int'(g.fs),  int'(e.fs));
  endtask

`ifdef VGA_TIMING_PREFETCH_EN
  task automatic chk_fetch();
    st_t f;
    f = mstep(md, 1'b1, cd);
    chk("def.fetchX", int'(d_fx), f.h);
    chk("def.fetchY", int'(d_fy), f.v);
    chk("def.fetchValid", int'(d_fv), int'(f.vid));
    f = mstep(mm, 1'b1, cm);
    chk("med.fetchX", int'(m_fx), f.h);
    chk("med.fetchY", int'(m_fy), f.v);
    chk("med.fetchValid", int'(m_fv), int'(f.vid));
    f = mstep(ms, 1'b1, cs);
    chk("sml.fetchX", int'(s_fx), f.h);
    chk("sml.fetchY", int'(s_fy), f.v);
    chk("sml.fetchValid", int'(s_fv), int'(f.vid));
  endtask
`endif

  // One clock: drive enables, queue model predictions, compare after the edge.
  task automatic tick(input bit pd, input bit pm, input bit ps);
    pe_d = pd; pe_m = pm; pe_s = ps;
`ifdef VGA_TIMING_PREFETCH_EN
    chk_fetch();
`endif
    md = rst_n ? mstep(md, pd, cd) : rst_state(cd);
    mm = rst_n ? mstep(mm, pm, cm) : rst_state(cm);
    ms = rst_n ? mstep(ms, ps, cs) : rst_state(cs);
    q_d.push_back(md);
    q_m.push_back(mm);
    q_s.push_back(ms);
    @(posedge clk);
    #1;
    cyc++;
    chk_st("def", obs_d(), q_d.pop_front());
    chk_st("med", obs_m(), q_m.pop_front());
    chk_st("sml", obs_s(), q_s.pop_front());
    if (s_fs) begin
      if (last_fs_s >= 0) per_s = cyc - last_fs_s;
      last_fs_s = cyc;
    end
    if (m_fs) begin
      if (last_fs_m >= 0) per_m = cyc - last_fs_m;
      last_fs_m = cyc;
    end
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic async_reset_check();
    rst_n = 1'b0;
    #1;
    md = rst_state(cd); mm = rst_state(cm); ms = rst_state(cs);
    q_d.push_back(md); q_m.push_back(mm); q_s.push_back(ms);
    chk_st("def.rst", obs_d(), q_d.pop_front());
    chk_st("med.rst", obs_m(), q_m.pop_front());
    chk_st("sml.rst", obs_s(), q_s.pop_front());
  endtask

  task automatic first_tick_check();
    tick(1'b1, 1'b1, 1'b1);
    chk("def.first.HControl", int'(d_h), 0);
    chk("def.first.VControl", int'(d_v), 0);
    chk("def.first.frameStart", int'(d_fs), 1);
    chk("def.first.lineStart", int'(d_ls), 1);
    chk("def.first.videoOn", int'(d_vid), 1);
  endtask

  initial begin
    int hs_low0, hs_low1, ls_cnt, dbl, prev_sh, prev_sv, steps;
    bit prev_sfs;
    cd = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cm = '{16, 2, 4, 3, 12, 3, 2, 4, 1'b0};
    cs = '{4, 1, 1, 1, 3, 1, 1, 1, 1'b1};
    pe_d = 1'b0; pe_m = 1'b0; pe_s = 1'b0;
    rst_n = 1'b1;
    #2;
    async_reset_check();
    // Clocks with enables high while in reset must not move anything.
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    first_tick_check();

    // pixEn tied high: two full default lines plus change.
    hs_low0 = 0; hs_low1 = 0; ls_cnt = 1;
    prev_sh = int'(s_h); prev_sv = int'(s_v);
    for (int i = 1; i < 1700; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (d_h == 10'd640) chk("def.videoOn@640", int'(d_vid), 0);
      if (d_v == 10'd0 && !d_hs) hs_low0++;
      if (d_v == 10'd1 && !d_hs) hs_low1++;
      if (d_ls) ls_cnt++;
      if (prev_sh == 6 && prev_sv == 5) begin
        chk("sml.wrap.HControl", int'(s_h), 0);
        chk("sml.wrap.VControl", int'(s_v), 0);
        chk("sml.wrap.frameStart", int'(s_fs), 1);
        chk("sml.wrap.lineStart", int'(s_ls), 1);
      end
      prev_sh = int'(s_h); prev_sv = int'(s_v);
    end
    chk("def.hsync_low_line0", hs_low0, 96);
    chk("def.hsync_low_line1", hs_low1, 96);
    chk("def.lineStart_count", ls_cnt, 3);
    chk("sml.frame_period_full", per_s, 42);
    chk("med.frame_period_full", per_m, 525);

    // pixEn every second clock: frame periods double, strobes stay 1 wide.
    last_fs_s = -1; last_fs_m = -1; per_s = 0; per_m = 0;
    dbl = 0; prev_sfs = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      tick(i[0], i[0], i[0]);
      if (prev_sfs && s_fs) dbl++;
      prev_sfs = s_fs;
    end
    chk("sml.frame_period_half", per_s, 84);
    chk("med.frame_period_half", per_m, 1050);
    chk("sml.frameStart_double", dbl, 0);

    // Irregular pixEn duty.
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Mid-frame reset once the default raster is at column 300.
    steps = 0;
    while (d_h != 10'd300 && steps < 900) begin
      tick(1'b1, 1'b1, 1'b1);
      steps++;
    end
    chk("def.reach_col300", int'(d_h), 300);
    async_reset_check();
    tick(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    first_tick_check();
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
